// File: rtl/write_arbiter.sv
// Writeback arbiter: per-source FIFOs feeding one round-robin grant per cycle
// into a registered write port shared by the integer and float register files.
module write_arbiter #(
  parameter int NSRC  = 3,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*5-1:0]    src_rd,
  input  logic [NSRC-1:0]      src_to_reg,
  input  logic [NSRC-1:0]      src_to_freg,
  input  logic [NSRC*XLEN-1:0] src_data,
  output logic                 reg_w_enable,
  output logic                 freg_w_enable,
  output logic [4:0]           reg_w_dest,
  output logic [XLEN-1:0]      reg_w_data,
  output logic [NSRC-1:0]      completed,
  output logic                 idle,
  output logic                 err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam int          PW       = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned NS       = NSRC;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]      fifo_rd   [NSRC][DEPTH];
  logic            fifo_reg  [NSRC][DEPTH];
  logic            fifo_freg [NSRC][DEPTH];
  logic [XLEN-1:0] fifo_data [NSRC][DEPTH];
  logic [AW-1:0]   wptr      [NSRC];
  logic [AW-1:0]   rptr      [NSRC];
  logic [CW-1:0]   cnt       [NSRC];

  logic [NSRC-1:0] full;
  logic [NSRC-1:0] empty;
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;

  logic [PW-1:0]   prio;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_valid;
  logic            fire;

  logic [4:0]      head_rd;
  logic            head_reg;
  logic            head_freg;
  logic [XLEN-1:0] head_data;
  logic            wr_int;
  logic            wr_fp;
  logic            out_valid;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NS) s = s - NS;
    return PW'(s);
  endfunction

  // Ready depends only on pre-edge occupancy, so a full FIFO never accepts
  // even when it is being popped on the same edge.
  always_comb begin
    full      = '0;
    empty     = '0;
    src_ready = '0;
    push      = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      full[i]      = (cnt[i] == FULL_CNT);
      empty[i]     = (cnt[i] == '0);
      src_ready[i] = rstn && !full[i] && !flush;
      push[i]      = src_valid[i] && src_ready[i];
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!gnt_valid && !empty[wrap_idx(prio, k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = wrap_idx(prio, k);
      end
    end
    fire = gnt_valid && !flush;
    pop  = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      pop[i] = fire && (gnt_idx == PW'(i));
    end
    head_rd   = fifo_rd[gnt_idx][rptr[gnt_idx]];
    head_reg  = fifo_reg[gnt_idx][rptr[gnt_idx]];
    head_freg = fifo_freg[gnt_idx][rptr[gnt_idx]];
    head_data = fifo_data[gnt_idx][rptr[gnt_idx]];
    wr_int    = head_reg && (head_rd != 5'd0);
    wr_fp     = head_freg && !head_reg;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NS; i++) begin
      if (push[i]) begin
        fifo_rd[i][wptr[i]]   <= src_rd[5*i +: 5];
        fifo_reg[i][wptr[i]]  <= src_to_reg[i];
        fifo_freg[i][wptr[i]] <= src_to_freg[i];
        fifo_data[i][wptr[i]] <= src_data[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < NS; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NS; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + AW'(1);
        if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Dest/data only move on a real strobe, so x0 and no-target retires
  // leave the shared write bus showing the last actual write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio          <= '0;
      out_valid     <= 1'b0;
      reg_w_enable  <= 1'b0;
      freg_w_enable <= 1'b0;
      completed     <= '0;
      err           <= 1'b0;
      reg_w_dest    <= '0;
      reg_w_data    <= '0;
    end else begin
      out_valid     <= fire;
      reg_w_enable  <= fire && wr_int;
      freg_w_enable <= fire && wr_fp;
      completed     <= pop;
      if (fire) prio <= wrap_idx(gnt_idx, 1);
      if (fire && (wr_int || wr_fp)) begin
        reg_w_dest <= head_rd;
        reg_w_data <= head_data;
      end
      if (fire && head_reg && head_freg) err <= 1'b1;
    end
  end

  assign idle = (&empty) && !out_valid;

endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_write_arbiter;
  localparam int NSRC  = 3;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b1;
  logic                 flush = 1'b0;
  logic [NSRC-1:0]      src_valid = '0;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*5-1:0]    src_rd = '0;
  logic [NSRC-1:0]      src_to_reg = '0;
  logic [NSRC-1:0]      src_to_freg = '0;
  logic [NSRC*XLEN-1:0] src_data = '0;
  logic                 reg_w_enable;
  logic                 freg_w_enable;
  logic [4:0]           reg_w_dest;
  logic [XLEN-1:0]      reg_w_data;
  logic [NSRC-1:0]      completed;
  logic                 idle;
  logic                 err;

  write_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd),
    .src_to_reg(src_to_reg), .src_to_freg(src_to_freg), .src_data(src_data),
    .reg_w_enable(reg_w_enable), .freg_w_enable(freg_w_enable),
    .reg_w_dest(reg_w_dest), .reg_w_data(reg_w_data),
    .completed(completed), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, integer priority pointer.
  typedef struct {
    logic [4:0]      rd;
    logic            tr;
    logic            tf;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            mq [NSRC][$];
  ent_t            m_e;
  int              mp = 0;
  int              g;
  logic [NSRC-1:0] m_rdy;
  logic            m_reg = 1'b0;
  logic            m_freg = 1'b0;
  logic [4:0]      m_dest = '0;
  logic [XLEN-1:0] m_data = '0;
  logic [NSRC-1:0] m_comp = '0;
  logic            m_err = 1'b0;
  logic            m_ov = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int i = 0; i < NSRC; i++) mq[i].delete();
        mp = 0; m_reg = 0; m_freg = 0; m_dest = '0; m_data = '0;
        m_comp = '0; m_err = 0; m_ov = 0;
      end else begin
        for (int i = 0; i < NSRC; i++) m_rdy[i] = (mq[i].size() < DEPTH) && !flush;
        m_reg = 0; m_freg = 0; m_comp = '0; m_ov = 0;
        if (flush) begin
          for (int i = 0; i < NSRC; i++) mq[i].delete();
        end else begin
          g = -1;
          for (int k = 0; k < NSRC; k++)
            if (g < 0 && mq[(mp + k) % NSRC].size() > 0) g = (mp + k) % NSRC;
          if (g >= 0) begin
            m_e = mq[g].pop_front();
            m_ov = 1;
            m_comp[g] = 1'b1;
            m_reg = m_e.tr && (m_e.rd != 0);
            m_freg = m_e.tf && !m_e.tr;
            if (m_reg || m_freg) begin
              m_dest = m_e.rd;
              m_data = m_e.d;
            end
            if (m_e.tr && m_e.tf) m_err = 1;
            mp = (g + 1) % NSRC;
          end
          for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i] && m_rdy[i]) begin
              m_e.rd = src_rd[5*i +: 5];
              m_e.tr = src_to_reg[i];
              m_e.tf = src_to_freg[i];
              m_e.d  = src_data[XLEN*i +: XLEN];
              mq[i].push_back(m_e);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NSRC-1:0] exp_rdy;
    logic            exp_idle;
    forever begin
      @(negedge clk);
      exp_idle = !m_ov;
      for (int i = 0; i < NSRC; i++) begin
        exp_rdy[i] = rstn && (mq[i].size() < DEPTH) && !flush;
        if (mq[i].size() != 0) exp_idle = 1'b0;
      end
      chk("cyc_reg_en",  reg_w_enable,  m_reg);
      chk("cyc_freg_en", freg_w_enable, m_freg);
      chk("cyc_dest",    reg_w_dest,    m_dest);
      chk("cyc_data",    reg_w_data,    m_data);
      chk("cyc_comp",    completed,     m_comp);
      chk("cyc_err",     err,           m_err);
      chk("cyc_idle",    idle,          exp_idle);
      chk("cyc_ready",   src_ready,     exp_rdy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd,
                         input logic tr, input logic tf, input logic [XLEN-1:0] d);
    src_valid[i]            = v;
    src_rd[5*i +: 5]        = rd;
    src_to_reg[i]           = tr;
    src_to_freg[i]          = tf;
    src_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic clr();
    src_valid = '0;
  endtask

  int acc0, acc2, c0, c2;
  logic a0, a2;

  initial begin
    #2 rstn = 1'b0;
    step();
    chk("rst_idle", idle, 1'b1);
    chk("rst_ready", src_ready, 3'b000);
    chk("rst_dest", reg_w_dest, 5'd0);
    chk("rst_reg_en", reg_w_enable, 1'b0);
    step();
    rstn = 1'b1;

    // single write
    set_src(1, 1, 5'd5, 1, 0, 32'hDEADBEEF);
    step();
    clr();
    chk("s1_lat_reg_en", reg_w_enable, 1'b0);
    chk("s1_lat_idle", idle, 1'b0);
    step();
    chk("s1_reg_en", reg_w_enable, 1'b1);
    chk("s1_dest", reg_w_dest, 5'd5);
    chk("s1_data", reg_w_data, 32'hDEADBEEF);
    chk("s1_comp", completed, 3'b010);
    chk("s1_model_dest", m_dest, 5'd5);
    chk("s1_model_comp", m_comp, 3'b010);
    step();
    chk("s1_idle_after", idle, 1'b1);
    chk("s1_reg_en_after", reg_w_enable, 1'b0);
    chk("s1_dest_hold", reg_w_dest, 5'd5);

    // round robin from p=0
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    set_src(0, 1, 5'd10, 1, 0, 32'hA0);
    set_src(1, 1, 5'd11, 1, 0, 32'hA1);
    set_src(2, 1, 5'd12, 1, 0, 32'hA2);
    step();
    clr();
    set_src(0, 1, 5'd13, 1, 0, 32'hA3);
    step();
    clr();
    chk("rr_g0", completed, 3'b001);
    chk("rr_g0_dest", reg_w_dest, 5'd10);
    step();
    chk("rr_g1", completed, 3'b010);
    chk("rr_g1_model", m_comp, 3'b010);
    step();
    chk("rr_g2", completed, 3'b100);
    step();
    chk("rr_g0b", completed, 3'b001);
    chk("rr_g0b_data", reg_w_data, 32'hA3);
    step();
    chk("rr_idle", idle, 1'b1);

    // float write from source 2 moves p back to 0
    set_src(2, 1, 5'd20, 0, 1, 32'hB0);
    step();
    clr();
    step();
    chk("fp_freg_en", freg_w_enable, 1'b1);
    chk("fp_reg_en", reg_w_enable, 1'b0);
    chk("fp_dest", reg_w_dest, 5'd20);
    chk("fp_comp", completed, 3'b100);
    step();

    // full FIFO on source 2 while source 0 stays busy
    acc0 = 0; acc2 = 0; c0 = 0; c2 = 0;
    for (int n = 0; n < 12; n++) begin
      set_src(0, 1, 5'd1, 1, 0, 32'h1000 + acc0);
      set_src(2, 1, 5'd2, 1, 0, 32'h2000 + acc2);
      a0 = src_ready[0];
      a2 = src_ready[2];
      if (n == 2) begin
        chk("full_acc2", acc2, 2);
        chk("full_ready2", src_ready[2], 1'b0);
        chk("full_ready0", src_ready[0], 1'b1);
      end
      step();
      if (a0) acc0++;
      if (a2) acc2++;
      if (completed[0]) c0++;
      if (completed[2]) c2++;
    end
    clr();
    for (int k = 0; k < 10 && !idle; k++) begin
      step();
      if (completed[0]) c0++;
      if (completed[2]) c2++;
    end
    chk("full_count2", c2, acc2);
    chk("full_count0", c0, acc0);
    chk("full_drained", idle, 1'b1);

    // x0, illegal and no-target entries
    chk("x0_err_before", err, 1'b0);
    set_src(1, 1, 5'd0, 1, 0, 32'hC0);
    step();
    clr();
    step();
    chk("x0_comp", completed, 3'b010);
    chk("x0_reg_en", reg_w_enable, 1'b0);
    chk("x0_freg_en", freg_w_enable, 1'b0);
    set_src(0, 1, 5'd7, 1, 1, 32'hC1);
    step();
    clr();
    step();
    chk("ill_reg_en", reg_w_enable, 1'b1);
    chk("ill_freg_en", freg_w_enable, 1'b0);
    chk("ill_err", err, 1'b1);
    chk("ill_dest", reg_w_dest, 5'd7);
    chk("ill_model_err", m_err, 1'b1);
    set_src(2, 1, 5'd9, 0, 0, 32'hC2);
    step();
    clr();
    step();
    chk("none_comp", completed, 3'b100);
    chk("none_reg_en", reg_w_enable, 1'b0);
    chk("none_freg_en", freg_w_enable, 1'b0);
    chk("none_dest_hold", reg_w_dest, 5'd7);
    chk("none_data_hold", reg_w_data, 32'hC1);

    // flush with 4 entries queued
    set_src(0, 1, 5'd3, 1, 0, 32'hD0);
    set_src(1, 1, 5'd4, 1, 0, 32'hD1);
    set_src(2, 1, 5'd5, 1, 0, 32'hD2);
    step();
    set_src(0, 1, 5'd6, 1, 0, 32'hD3);
    set_src(1, 1, 5'd8, 1, 0, 32'hD4);
    src_valid[2] = 1'b0;
    step();
    clr();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_idle", idle, 1'b1);
    chk("fl_reg_en", reg_w_enable, 1'b0);
    chk("fl_comp", completed, 3'b000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fl_no_strobe", {reg_w_enable, freg_w_enable, completed}, 5'b0);
    end
    chk("fl_err_sticky", err, 1'b1);

    // asynchronous reset with queued entries and a write on the bus
    set_src(0, 1, 5'd6, 1, 0, 32'hE0);
    set_src(1, 1, 5'd8, 1, 0, 32'hE1);
    step();
    clr();
    set_src(2, 1, 5'd9, 1, 0, 32'hE2);
    step();
    clr();
    chk("ar_pre_reg_en", reg_w_enable, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_reg_en", reg_w_enable, 1'b0);
    chk("ar_comp", completed, 3'b000);
    chk("ar_dest", reg_w_dest, 5'd0);
    chk("ar_data", reg_w_data, 32'h0);
    chk("ar_err", err, 1'b0);
    chk("ar_idle", idle, 1'b1);
    chk("ar_ready", src_ready, 3'b000);
    step();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ar_no_write", {reg_w_enable, freg_w_enable, completed}, 5'b0);
      chk("ar_idle_after", idle, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/write_arbiter.md
WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 The block SHALL have parameter NSRC, default 3, meaning the number of writeback sources.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning entries per source FIFO (power of two, >=2).
REQ-003 The block SHALL have parameter XLEN, default 32, meaning the data width.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rstn  in  1  asynchronous, active-low reset.
REQ-006 Port: flush  in  1  synchronous discard of all queued and pending writes.
REQ-007 Port: src_valid  in  NSRC  per-source request.
REQ-008 Port: src_ready  out  NSRC  per-source accept.
REQ-009 Port: src_rd  in  NSRC*5  destination register, source i in bits [5i+4:5i].
REQ-010 Port: src_to_reg  in  NSRC  entry targets the integer file.
REQ-011 Port: src_to_freg  in  NSRC  entry targets the float file.
REQ-012 Port: src_data  in  NSRC*XLEN  write data, source i in bits [XLEN*i+XLEN-1:XLEN*i].
REQ-013 Port: reg_w_enable  out  1  integer-file write strobe.
REQ-014 Port: freg_w_enable  out  1  float-file write strobe.
REQ-015 Port: reg_w_dest  out  5  destination index, shared by both files.
REQ-016 Port: reg_w_data  out  XLEN  write data, shared by both files.
REQ-017 Port: completed  out  NSRC  one-cycle retire pulse per source.
REQ-018 Port: idle  out  1  all FIFOs empty and no write in the output register.
REQ-019 Port: err  out  1  sticky illegal-entry flag.

Function
REQ-020 Each source SHALL own a DEPTH-entry FIFO holding {rd, to_reg, to_freg, data}, with wrapping read/write pointers and an occupancy counter of width clog2(DEPTH)+1.
REQ-021 src_ready[i] SHALL equal !full[i] && !flush; there is no pass-through when full, even if the FIFO pops in the same cycle.
REQ-022 An entry SHALL be pushed on a rising edge where src_valid[i] && src_ready[i]; a simultaneous push and pop on one FIFO SHALL leave occupancy unchanged.
REQ-023 A pushed entry SHALL become eligible for arbitration no earlier than the cycle after it is pushed (no bypass).
REQ-024 Each cycle, one non-empty FIFO head SHALL be granted by round-robin, searching from priority pointer p upward modulo NSRC.
REQ-025 After a grant to source g, p SHALL become (g+1) mod NSRC; with no grant, p SHALL hold.
REQ-026 The granted head SHALL be popped and loaded into a registered output stage, so that the write strobes, dest, data and completed[g] are asserted for exactly one cycle after the grant edge.
REQ-027 Minimum latency SHALL be 2 cycles from the push edge to the cycle in which the strobe is visible, with sustained throughput of one write per cycle.
REQ-028 reg_w_enable SHALL equal to_reg && rd!=0; writes to x0 SHALL retire with completed pulsed and no strobe.
REQ-029 freg_w_enable SHALL equal to_freg && !to_reg.
REQ-030 An entry with both to_reg and to_freg set SHALL write only the integer file, and SHALL set err, which holds until reset.
REQ-031 An entry with neither flag set SHALL retire with completed pulsed and both strobes low.
REQ-032 While neither strobe is asserted, reg_w_dest and reg_w_data SHALL hold their last values.
REQ-033 When flush is high at an edge, the block SHALL:
- empty all FIFOs;
- accept no push;
- perform no grant;
- drive the strobes and completed to 0 in the following cycle;
- leave p and err unchanged.
REQ-034 idle SHALL be combinational: all occupancy counters zero and output-stage valid low.

Reset
REQ-035 When rstn is low, the block SHALL immediately clear:
- all FIFO pointers and counters;
- p to 0;
- the output-stage valid bit and completed;
- err;
- reg_w_dest and reg_w_data to 0.
REQ-036 During reset, reg_w_enable, freg_w_enable and src_ready SHALL be 0 and idle SHALL be 1.
REQ-037 Reset asserted mid-operation SHALL discard all queued entries with no partial write; normal operation SHALL resume on the first edge after rstn rises.

Verification
REQ-038 Scenario (single write): source 1 pushes rd=5, to_reg=1, data=0xDEADBEEF at edge N -> during the cycle after edge N+1, reg_w_enable=1, reg_w_dest=5, reg_w_data=0xDEADBEEF, completed=3'b010; idle=1 afterward.
REQ-039 Scenario (round-robin): all 3 sources push together at edge N -> grants occur in the order 0,1,2 on consecutive cycles; a further push to source 0 at edge N+1 is then granted after source 2.
REQ-040 Scenario (full FIFO): source 2 keeps src_valid high with DEPTH=2 while source 0 is kept busy continuously -> src_ready[2]=0 after 2 accepts; no entry is lost or duplicated; data emerges in FIFO order.
REQ-041 Scenario (x0 and illegal entries): rd=0 with to_reg=1 -> completed pulses and reg_w_enable=0; an entry with to_reg=1 and to_freg=1 -> reg_w_enable=1, freg_w_enable=0, err=1 sticky through a later flush.
REQ-042 Scenario (flush and reset): 4 entries queued, then flush at edge N -> no strobe after N, idle=1; reset asserted between two edges with queued entries -> outputs clear asynchronously, and no write occurs after rstn rises.
